// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch definitions: FSM states, IR field bounds, PC step, NOP
package instr_fetch_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_ir_fields.sv
// rtl/instr_fetch_ir_fields.sv - combinational MIPS field slicer, shared with decode
module ir_fields
  import instr_fetch_pkg::*;
(
  input  logic [31:0] ir_instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign opcode = ir_instr[OPC_MSB:OPC_LSB];
  assign rs     = ir_instr[RS_MSB:RS_LSB];
  assign rt     = ir_instr[RT_MSB:RT_LSB];
  assign rd     = ir_instr[RD_MSB:RD_LSB];
  assign shamt  = ir_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = ir_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = ir_instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem request FSM, IR and decoded fields
// Optional IFETCH_TRACE_EN adds the fetch_cnt consumed-instruction counter.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [31:0]       ir_instr,
  output logic [31:0]       ir_pc,
  output logic [31:0]       ir_pc4,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
`ifdef IFETCH_TRACE_EN
  ,
  output logic [CNT_W-1:0]  fetch_cnt
`endif
);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        load_ir;
  logic        consume;
  logic        req_state;

  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    consume   = 1'b0;
    req_state = 1'b0;
    case (state)
      S_REQ: begin
        req_state = 1'b1;
        if (imem_ready) begin
          load_ir   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_ready) begin
          consume   = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    // A redirect kills any returning word but a same-cycle consume still counts.
    if (redirect_valid) begin
      load_ir   = 1'b0;
      state_nxt = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= word_align(RESET_PC);
      ir_valid <= 1'b0;
      ir_instr <= NOP_INSTR;
      ir_pc    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        ir_valid <= 1'b0;
      end else if (load_ir) begin
        pc       <= pc + PC_STEP;
        ir_instr <= imem_rdata;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
      end else if (consume) begin
        ir_valid <= 1'b0;
      end
    end
  end

  // Gating with rst_n keeps the request low in the reset cycle itself.
  assign imem_req  = rst_n & req_state;
  assign imem_addr = pc;
  assign ir_pc4    = ir_pc + PC_STEP;

  ir_fields u_ir_fields (
    .ir_instr (ir_instr),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16)
  );

`ifdef IFETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (consume) begin
      fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed plus randomized bench for instr_fetch against a behavioural model
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ready, ir_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir_instr, ir_pc, ir_pc4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] fetch_cnt_w;

  logic        w_ready, w_ir_ready;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16;
  logic [31:0] w_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_ir, m_irpc, m_cnt;
  logic        m_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc), .ir_pc4(ir_pc4),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFETCH_TRACE_EN
    , .fetch_cnt(fetch_cnt_w)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(32'h1234_5678),
    .ir_valid(w_valid), .ir_ready(w_ir_ready), .ir_instr(w_instr), .ir_pc(w_pc), .ir_pc4(w_pc4),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct), .imm16(w_imm16),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef IFETCH_TRACE_EN
    , .fetch_cnt(w_cnt)
`endif
  );

`ifndef IFETCH_TRACE_EN
  assign fetch_cnt_w = 32'h0;
  assign w_cnt       = 32'h0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, rst_n & ~m_valid});
    chk("imem_addr", imem_addr, m_pc);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    chk("ir_instr", ir_instr, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
    chk("ir_pc4", ir_pc4, m_irpc + 32'd4);
    chk("opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
    chk("rs", {27'b0, rs}, {27'b0, m_ir[25:21]});
    chk("rt", {27'b0, rt}, {27'b0, m_ir[20:16]});
    chk("rd", {27'b0, rd}, {27'b0, m_ir[15:11]});
    chk("shamt", {27'b0, shamt}, {27'b0, m_ir[10:6]});
    chk("funct", {26'b0, funct}, {26'b0, m_ir[5:0]});
    chk("imm16", {16'b0, imm16}, {16'b0, m_ir[15:0]});
`ifdef IFETCH_TRACE_EN
    chk("fetch_cnt", fetch_cnt_w, m_cnt);
`endif
  endtask

  // One clock: apply inputs, advance the model at the edge, check at the falling edge.
  task automatic cycle(input logic rst, input logic rdy, input logic [31:0] rdata,
                       input logic irr, input logic rv, input logic [31:0] rpc);
    rst_n          = rst;
    imem_ready     = rdy;
    imem_rdata     = rdata;
    ir_ready       = irr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    if (!rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_ir = 32'h0; m_irpc = 32'h0; m_cnt = 32'h0;
    end else if (rv) begin
      if (m_valid && irr) m_cnt = m_cnt + 1;
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!m_valid && rdy) begin
      m_ir    = rdata;
      m_irpc  = m_pc;
      m_pc    = m_pc + 4;
      m_valid = 1'b1;
    end else if (m_valid && irr) begin
      m_valid = 1'b0;
      m_cnt   = m_cnt + 1;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    w_ready = 1'b0;
    w_ir_ready = 1'b0;
    m_pc = 32'h0; m_valid = 1'b0; m_ir = 32'h0; m_irpc = 32'h0; m_cnt = 32'h0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    imem_ready = 1'b0;
    #1;
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);

    // First fetch with a negative immediate
    cycle(1'b1, 1'b1, 32'h2008_FFFF, 1'b0, 1'b0, 32'h0);
    chk("fetch_opcode", {26'b0, opcode}, 32'h08);
    chk("fetch_rt", {27'b0, rt}, 32'd8);
    chk("fetch_imm16", {16'b0, imm16}, 32'h0000_FFFF);
    chk("fetch_sext", {{16{imm16[15]}}, imm16}, 32'hFFFF_FFFF);
    chk("fetch_ir_pc", ir_pc, 32'h0);
    chk("fetch_ir_pc4", ir_pc4, 32'h4);

    // Backpressure, then consume
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("after_consume_req", {31'b0, imem_req}, 32'd1);
    chk("after_consume_addr", imem_addr, 32'h4);

    // Memory wait states
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 32'h0);

    // Redirect colliding with a returning word
    cycle(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0043);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", {31'b0, ir_valid}, 32'd0);
    chk("redir_ir_kept", ir_instr, 32'h2008_FFFF);

    // Redirect together with consume in the hold state
    cycle(1'b1, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100);
    chk("redir_hold_addr", imem_addr, 32'h100);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 1) == 1),
            $urandom(),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0),
            $urandom());
    end

    // PC wrap on the second instance, then three consumes
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
    w_ready = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_ir_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_ir_pc4", w_pc4, 32'h0);
    w_ir_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_final_addr", w_addr, 32'h8);
`ifdef IFETCH_TRACE_EN
    chk("wrap_fetch_cnt", w_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
